// File: rtl/tour_pkg.sv
// Shared definitions for the knight's-tour replay block.
// Holds the FSM state enum, command opcodes and headings, the default tour
// length and square-field width, and the one-hot move to (dx,dy) table.
package tour_pkg;

    localparam int NUM_MOVES_DEF = 24;
    localparam int SQ_W_DEF      = 4;

    typedef enum logic [2:0] {
        IDLE,
        VERT,
        VWAIT,
        HORZ,
        HWAIT,
        FIN
    } state_t;

    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_FANFARE = 4'h3;

    localparam logic [7:0] HDG_NORTH = 8'h00;
    localparam logic [7:0] HDG_WEST  = 8'h3F;
    localparam logic [7:0] HDG_SOUTH = 8'h7F;
    localparam logic [7:0] HDG_EAST  = 8'hBF;

    typedef struct packed {
        logic signed [2:0] dx;
        logic signed [2:0] dy;
    } delta_t;

    // Entry i is the displacement for move bit i.
    localparam delta_t MOVE_TBL [8] = '{
        '{dx:  3'sd1, dy:  3'sd2},
        '{dx: -3'sd1, dy:  3'sd2},
        '{dx: -3'sd2, dy:  3'sd1},
        '{dx: -3'sd2, dy: -3'sd1},
        '{dx: -3'sd1, dy: -3'sd2},
        '{dx:  3'sd1, dy: -3'sd2},
        '{dx:  3'sd2, dy: -3'sd1},
        '{dx:  3'sd2, dy:  3'sd1}
    };

    // Magnitude of a small signed displacement.
    function automatic logic [2:0] mag3(input logic signed [2:0] d);
        return d[2] ? 3'(-d) : d;
    endfunction

endpackage

// File: rtl/tour_replay_if.sv
// Command channel between the tour replayer and the motion consumer.
//   cmd     : 16-bit motion command {opcode, heading, squares}
//   cmd_vld : command valid, held with cmd stable until cmd_ack
//   cmd_ack : consumer accepted the command this cycle
//   resp    : one-cycle pulse, commanded leg complete
interface tour_replay_if;
    logic [15:0] cmd;
    logic        cmd_vld;
    logic        cmd_ack;
    logic        resp;

    modport master (output cmd, cmd_vld, input cmd_ack, resp);
    modport slave  (input cmd, cmd_vld, output cmd_ack, resp);
endinterface

// File: rtl/tour_move_decode.sv
// Purely combinational knight-move decoder.
//   move  : one-hot move code
//   dx,dy : signed displacement of the move (don't-care when !legal)
//   legal : move is exactly one-hot
module tour_move_decode
    import tour_pkg::*;
(
    input  logic [7:0]        move,
    output logic signed [2:0] dx,
    output logic signed [2:0] dy,
    output logic              legal
);

    always_comb begin
        // NOTE: every output gets a value before any branch, so no latch is inferred.
        dx    = '0;
        dy    = '0;
        legal = $onehot(move);
        for (int i = 0; i < 8; i++) begin
            if (move[i]) begin
                dx = MOVE_TBL[i].dx;
                dy = MOVE_TBL[i].dy;
            end
        end
    end

endmodule

// File: rtl/tour_replay.sv
// Replays a solved knight's tour as motion commands.
//   clk, rst : clock and synchronous active-high reset
//   start    : pulse in IDLE begins replay from move 0
//   move     : one-hot move for index mv_indx, supplied by the tour solver
//   mv_indx  : move index presented to the solver
//   cmd_bus  : command channel (cmd / cmd_vld / cmd_ack / resp)
//   busy     : high in every state except IDLE
//   done     : one-cycle pulse when the tour ends
//   err      : sticky flag, an illegal move code was seen
// Each move is issued as a vertical leg then a horizontal leg.
module tour_replay
    import tour_pkg::*;
#(
    parameter int NUM_MOVES = NUM_MOVES_DEF,
    parameter int SQ_W      = SQ_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           move,
    output logic [4:0]           mv_indx,
    tour_replay_if.master        cmd_bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

    state_t            state_q, state_d;
    logic [7:0]        move_q;
    logic              fresh_q;     // first cycle in VERT: move input not yet captured
    logic              clr_run, inc_indx, set_err;
    logic signed [2:0] dx, dy;
    logic              legal;
    logic [SQ_W-1:0]   sq_v, sq_h;
    logic [7:0]        hdg_v, hdg_h;
    logic [15:0]       cmd_v, cmd_h;

    tour_move_decode u_decode (
        .move  (move_q),
        .dx    (dx),
        .dy    (dy),
        .legal (legal)
    );

    // Knight moves never have a zero component, so sign alone picks the heading.
    assign sq_v  = SQ_W'(mag3(dy));
    assign sq_h  = SQ_W'(mag3(dx));
    assign hdg_v = dy[2] ? HDG_SOUTH : HDG_NORTH;
    assign hdg_h = dx[2] ? HDG_WEST  : HDG_EAST;
    assign cmd_v = {OP_MOVE,    hdg_v, 4'(sq_v)};
    assign cmd_h = {OP_FANFARE, hdg_h, 4'(sq_h)};

    assign busy = (state_q != IDLE);
    assign done = (state_q == FIN);

    always_comb begin
        state_d         = state_q;
        clr_run         = 1'b0;
        inc_indx        = 1'b0;
        set_err         = 1'b0;
        cmd_bus.cmd_vld = 1'b0;
        cmd_bus.cmd     = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clr_run = 1'b1;
                    state_d = VERT;
                end
            end
            VERT: begin
                // The capture cycle gives the solver one cycle to follow mv_indx.
                if (!fresh_q) begin
                    if (!legal) begin
                        set_err = 1'b1;
                        state_d = FIN;
                    end else begin
                        cmd_bus.cmd_vld = 1'b1;
                        cmd_bus.cmd     = cmd_v;
                        if (cmd_bus.cmd_ack) state_d = VWAIT;
                    end
                end
            end
            VWAIT: begin
                if (cmd_bus.resp) state_d = HORZ;
            end
            HORZ: begin
                cmd_bus.cmd_vld = 1'b1;
                cmd_bus.cmd     = cmd_h;
                if (cmd_bus.cmd_ack) state_d = HWAIT;
            end
            HWAIT: begin
                if (cmd_bus.resp) begin
                    if (mv_indx == LAST_INDX) begin
                        state_d = FIN;
                    end else begin
                        inc_indx = 1'b1;
                        state_d  = VERT;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            mv_indx <= '0;
            err     <= 1'b0;
            move_q  <= '0;
            fresh_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fresh_q <= (state_d == VERT) && (state_q != VERT);
            if (clr_run)       mv_indx <= '0;
            else if (inc_indx) mv_indx <= mv_indx + 5'd1;
            if (clr_run)       err <= 1'b0;
            else if (set_err)  err <= 1'b1;
            if (state_q == VERT && fresh_q) move_q <= move;
        end
    end

endmodule

// File: tb/tb_tour_replay.sv
// Randomized scoreboard bench for tour_replay.
module tb_tour_replay;

    localparam int N = 24;

    logic       clk = 1'b0;
    logic       rst_main, rst_inj, rst;
    logic       start_main, start_junk, start;
    logic [7:0] move;
    logic [4:0] mv_indx;
    logic       busy, done, err;
    logic [7:0] tour [32];

    tour_replay_if bus ();

    always #5 clk = ~clk;

    assign rst   = rst_main | rst_inj;
    assign start = start_main | start_junk;
    assign move  = tour[mv_indx];

    tour_replay #(.NUM_MOVES(N), .SQ_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .move    (move),
        .mv_indx (mv_indx),
        .cmd_bus (bus),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: knight displacement per move bit, legs built from sign/magnitude.
    int mdx [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
    int mdy [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

    typedef struct {
        logic [15:0] cmd;
        logic [4:0]  idx;
    } exp_t;

    exp_t exp_q [$];
    bit   exp_done_q [$];

    function automatic bit is_legal(input logic [7:0] m);
        return $countones(m) == 1;
    endfunction

    function automatic logic [15:0] leg(input logic [3:0] op, input int d, input bit vertical);
        logic [7:0] h;
        if (vertical) h = (d > 0) ? 8'h00 : 8'h7F;
        else          h = (d > 0) ? 8'hBF : 8'h3F;
        return {op, h, 4'(d < 0 ? -d : d)};
    endfunction

    task automatic push_expected();
        for (int i = 0; i < N; i++) begin
            int k;
            if (!is_legal(tour[i])) begin
                exp_done_q.push_back(1'b1);
                return;
            end
            k = 0;
            for (int b = 0; b < 8; b++) if (tour[i][b]) k = b;
            exp_q.push_back('{cmd: leg(4'h2, mdy[k], 1'b1), idx: 5'(i)});
            exp_q.push_back('{cmd: leg(4'h3, mdx[k], 1'b0), idx: 5'(i)});
        end
        exp_done_q.push_back(1'b0);
    endtask

    // Responder knobs, written by the main sequence.
    int ack_lo, ack_hi, resp_lo, resp_hi;
    bit junk_en, inj_arm;

    // Responder: acks commands, returns resp pulses, injects noise and a mid-tour reset.
    initial begin
        bit pend, horiz, inj_done;
        int cnt, ack_wait, lat;
        bus.cmd_ack = 1'b0;
        bus.resp    = 1'b0;
        start_junk  = 1'b0;
        rst_inj     = 1'b0;
        pend = 0; horiz = 0; inj_done = 0; cnt = 0; ack_wait = 0; lat = 0;
        forever begin
            @(posedge clk);
            #1;
            bus.resp    = 1'b0;
            bus.cmd_ack = 1'b0;
            start_junk  = 1'b0;
            rst_inj     = 1'b0;
            if (lat == 2) begin
                check("lat_resp_gap", bus.cmd_vld, 0);
                lat--;
            end else if (lat == 1) begin
                check("lat_resp_vld", bus.cmd_vld, is_legal(tour[mv_indx]));
                lat--;
            end
            if (rst_main) begin
                pend = 0;
                lat = 0;
                ack_wait = $urandom_range(ack_lo, ack_hi);
            end else if (pend) begin
                if (cnt > 0) begin
                    cnt--;
                end else begin
                    pend = 0;
                    if (horiz && inj_arm && !inj_done && mv_indx == 5'd12) begin
                        rst_inj  = 1'b1;
                        inj_done = 1;
                    end else begin
                        bus.resp = 1'b1;
                        if (horiz && mv_indx != 5'(N - 1)) lat = 2;
                    end
                end
            end else if (bus.cmd_vld) begin
                if (ack_wait > 0) begin
                    ack_wait--;
                    if (junk_en && $urandom_range(0, 2) == 0) bus.resp = 1'b1;
                end else begin
                    bus.cmd_ack = 1'b1;
                    pend     = 1;
                    horiz    = (bus.cmd[15:12] == 4'h3);
                    cnt      = $urandom_range(resp_lo, resp_hi);
                    ack_wait = $urandom_range(ack_lo, ack_hi);
                end
            end
            if (junk_en && busy && !rst_main && $urandom_range(0, 3) == 0) start_junk = 1'b1;
        end
    end

    // Monitor: compares every presented command and done pulse against the scoreboard.
    initial begin
        bit rst_prev, done_prev;
        rst_prev = 0;
        done_prev = 0;
        forever begin
            @(negedge clk);
            if (rst_prev) begin
                check("rst_mv_indx", mv_indx, 0);
                check("rst_cmd_vld", bus.cmd_vld, 0);
                check("rst_cmd", bus.cmd, 16'h0000);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_err", err, 0);
            end
            rst_prev = rst;
            if (rst) begin
                exp_q.delete();
                exp_done_q.delete();
                done_prev = 0;
            end else begin
                if (bus.cmd_vld) begin
                    if (exp_q.size() == 0) begin
                        check("cmd_unexpected", bus.cmd_vld, 0);
                    end else begin
                        check("cmd", bus.cmd, exp_q[0].cmd);
                        check("cmd_idx", mv_indx, exp_q[0].idx);
                        if (bus.cmd_ack) void'(exp_q.pop_front());
                    end
                end
                if (done) begin
                    if (exp_done_q.size() == 0) begin
                        check("done_unexpected", done, 0);
                    end else begin
                        check("done_err", err, exp_done_q.pop_front());
                        check("done_cmds_left", exp_q.size(), 0);
                        check("done_busy", busy, 1);
                    end
                end
                if (done_prev) check("done_width", done, 0);
                done_prev = done;
            end
        end
    end

    task automatic rand_tour();
        for (int i = 0; i < 32; i++) tour[i] = 8'(1 << $urandom_range(0, 7));
    endtask

    task automatic set_delays(input int alo, input int ahi, input int rlo, input int rhi);
        ack_lo = alo; ack_hi = ahi; resp_lo = rlo; resp_hi = rhi;
    endtask

    task automatic run_tour();
        int t;
        push_expected();
        @(posedge clk);
        #1 start_main = 1'b1;
        @(posedge clk);
        #1 start_main = 1'b0;
        @(negedge clk);
        check("start_vld_gap", bus.cmd_vld, 0);
        check("start_busy", busy, 1);
        check("start_mv_indx", mv_indx, 0);
        check("start_err_clr", err, 0);
        @(negedge clk);
        check("start_vld", bus.cmd_vld, is_legal(tour[0]));
        t = 0;
        while (busy && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check("run_ends", busy, 0);
        repeat (3) @(negedge clk);
        check("exp_cmds_drained", exp_q.size(), 0);
        check("exp_done_drained", exp_done_q.size(), 0);
    endtask

    initial begin
        rst_main   = 1'b1;
        start_main = 1'b0;
        junk_en    = 0;
        inj_arm    = 0;
        set_delays(3, 3, 3, 3);
        for (int i = 0; i < 32; i++) tour[i] = 8'h01;
        repeat (3) @(posedge clk);
        #1 rst_main = 1'b0;

        // Straight tour of identical moves with fixed 3-cycle ack/resp.
        run_tour();

        // South-west move first, random remainder and delays.
        rand_tour();
        tour[0] = 8'h08;
        set_delays(0, 3, 0, 3);
        run_tour();

        // Consumer stalls for 10 cycles on every command.
        rand_tour();
        set_delays(10, 10, 0, 2);
        run_tour();

        // Two-hot code at index 5 aborts with err.
        rand_tour();
        tour[5] = 8'h03;
        set_delays(0, 2, 0, 2);
        run_tour();

        // Empty code at a random index, then a clean run clears err.
        rand_tour();
        tour[$urandom_range(0, N - 1)] = 8'h00;
        run_tour();

        // Spurious start and resp pulses while busy.
        rand_tour();
        junk_en = 1;
        run_tour();
        junk_en = 0;

        // Reset during HWAIT at index 12, then replay from index 0.
        rand_tour();
        inj_arm = 1;
        run_tour();
        inj_arm = 0;
        rand_tour();
        junk_en = 1;
        run_tour();
        junk_en = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
